// File: rtl/spi_tx_push_arbiter.sv
// Round-robin arbiter sharing the SPI receiver's transmit push port among NUM_REQ producers.
// One push outstanding at a time. The granted word is held until push_done or a timeout.
module spi_tx_push_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic                       push_request,
  output logic [DATA_W-1:0]          push_data,
  input  logic                       push_done,
  input  logic                       tq_overflow,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease} stateT;

  stateT                stateQ, stateD;
  logic [IdW-1:0]       lastQ, lastD;
  logic [IdW-1:0]       grantQ, grantD;
  logic [DATA_W-1:0]    dataQ, dataD;
  logic [CntW-1:0]      cntQ, cntD;
  logic [NUM_REQ-1:0]   doneQ, doneD;
  logic                 errQ, errD;

  logic                 selFound;
  logic [IdW-1:0]       selIdx;
  int unsigned          scanIdx;

  // Find the first active request after the last winner, wrapping around.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    scanIdx  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scanIdx = (32'(lastQ) + k) % NUM_REQ;
      if (!selFound && req[scanIdx]) begin
        selFound = 1'b1;
        selIdx   = IdW'(scanIdx);
      end
    end
  end

  // Next-state logic: grant in idle, wait for ack or timeout, then one release cycle.
  always_comb begin
    stateD = stateQ;
    lastD  = lastQ;
    grantD = grantQ;
    dataD  = dataQ;
    cntD   = cntQ;
    doneD  = '0;
    errD   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (selFound && !tq_overflow) begin
          grantD = selIdx;
          lastD  = selIdx;
          dataD  = req_data[int'(selIdx) * DATA_W +: DATA_W];
          cntD   = '0;
          stateD = StIssue;
        end
      end
      StIssue: begin
        if (cntQ != CntW'(TIMEOUT)) begin
          cntD = cntQ + 1'b1;
        end
        // An ack on the final allowed cycle still counts as success.
        if (push_done) begin
          doneD[grantQ] = 1'b1;
          stateD        = StRelease;
        end else if (cntQ == CntW'(TIMEOUT - 1)) begin
          doneD[grantQ] = 1'b1;
          errD          = 1'b1;
          stateD        = StRelease;
        end
      end
      StRelease: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      lastQ  <= IdW'(NUM_REQ - 1);
      grantQ <= '0;
      dataQ  <= '0;
      cntQ   <= '0;
      doneQ  <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      lastQ  <= lastD;
      grantQ <= grantD;
      dataQ  <= dataD;
      cntQ   <= cntD;
      doneQ  <= doneD;
      errQ   <= errD;
    end
  end

  // Outputs decoded from registered state so done and push_request never overlap.
  always_comb begin
    push_request = (stateQ == StIssue);
    busy         = (stateQ != StIdle);
    push_data    = dataQ;
    grant_id     = grantQ;
    done         = doneQ;
    err          = errQ;
  end

endmodule
